divider_ctrl: RTL and testbench

Run/stop and ratio controller for the divide-by-N clock-enable path. Holds the active divide ratio (reset ratio 4), accepts new ratios over a valid/ready handshake, and applies them only at a period boundary, so `div_clk` and `div_en` never produce a truncated or glitched period. Downstream divider logic (the `divider4` family) consumes `div_en` and `div_clk` from this block.

---
 rtl/divider_ctrl.sv | 161 ++++++++++++++++
 tb/tb_divider_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_ctrl.sv
// divider_ctrl: run/stop and ratio controller for the divide-by-N clock-enable path.
// Holds the active divide ratio, takes new ratios over a valid/ready handshake and
// applies them only at a period boundary, so div_clk/div_en never glitch or truncate.
//
// Optional feature macro: DIVIDER_CTRL_PERIOD_CNT_EN (adds period_clr / period_cnt).
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start, stop       level-sampled run/stop requests (stop wins when both high)
//   cfg_valid/cfg_div new ratio offer; cfg_ready = pending slot empty
//   cfg_err           one-cycle pulse: offered ratio < 2 was discarded
//   div_en            one-cycle pulse in the last cycle of each period
//   div_clk           divided clock (high for floor(N/2) cycles of each period)
//   busy              RUN or DRAIN
//   cur_div           ratio currently in effect
//   period_clr        (optional) zero the period counter
//   period_cnt        (optional) 16-bit count of completed busy periods
module divider_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RST_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DIVIDER_CTRL_PERIOD_CNT_EN
  input  logic             period_clr,
  output logic [15:0]      period_cnt,
`endif
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_en,
  output logic             div_clk,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] cur_div_nx;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] pend_div_nx;
  logic             pend_vld;
  logic             pend_vld_nx;

  logic             active;
  logic             boundary;
  logic             go;
  logic             cfg_fire;
  logic             cfg_bad;
  logic             apply;

  logic             busy_nx;
  logic             div_clk_nx;
  logic             div_en_nx;
  logic             cfg_ready_nx;
  logic             cfg_err_nx;

  assign active   = (state != IDLE);
  assign boundary = active & (cnt == cur_div - CNT_W'(1));
  assign go       = start & ~stop;
  assign cfg_fire = cfg_valid & cfg_ready;
  assign cfg_bad  = (cfg_div < CNT_W'(2));
  // Pending ratio lands immediately when idle, otherwise only on the wrap edge.
  assign apply    = pend_vld & (~active | boundary);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = RUN;
      RUN:     if (stop) state_nx = boundary ? IDLE : DRAIN;
      DRAIN: begin
        if (go)            state_nx = RUN;
        else if (boundary) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counter and ratio datapath next values
  always_comb begin
    cnt_nx      = '0;
    cur_div_nx  = cur_div;
    pend_div_nx = pend_div;
    pend_vld_nx = pend_vld;
    if (active && (state_nx != IDLE)) begin
      cnt_nx = boundary ? '0 : cnt + CNT_W'(1);
    end
    if (apply) begin
      cur_div_nx  = pend_div;
      pend_vld_nx = 1'b0;
    end
    // cfg_ready mirrors ~pend_vld, so a capture never coincides with an apply.
    if (cfg_fire && !cfg_bad) begin
      pend_div_nx = cfg_div;
      pend_vld_nx = 1'b1;
    end
  end

  // Output next values, derived from the post-edge counter/ratio so the
  // registered outputs line up with cnt in the same cycle.
  always_comb begin
    busy_nx      = (state_nx != IDLE);
    div_clk_nx   = busy_nx & (cnt_nx < (cur_div_nx >> 1));
    div_en_nx    = busy_nx & (cnt_nx == cur_div_nx - CNT_W'(1));
    cfg_ready_nx = ~pend_vld_nx;
    cfg_err_nx   = cfg_fire & cfg_bad;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      cur_div   <= CNT_W'(RST_DIV);
      pend_div  <= '0;
      pend_vld  <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      div_en    <= 1'b0;
      div_clk   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      cur_div   <= cur_div_nx;
      pend_div  <= pend_div_nx;
      pend_vld  <= pend_vld_nx;
      cfg_ready <= cfg_ready_nx;
      cfg_err   <= cfg_err_nx;
      div_en    <= div_en_nx;
      div_clk   <= div_clk_nx;
      busy      <= busy_nx;
    end
  end

`ifdef DIVIDER_CTRL_PERIOD_CNT_EN
  // Busy period counter; clear takes priority over a same-cycle boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             period_cnt <= '0;
    else if (period_clr) period_cnt <= '0;
    else if (boundary)   period_cnt <= period_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_divider_ctrl.sv
// Scoreboard bench for divider_ctrl: a period-level reference model predicts the
// outputs after every edge; a separate monitor compares them on the falling edge.
module tb_divider_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready;
  logic       cfg_err;
  logic       div_en;
  logic       div_clk;
  logic       busy;
  logic [7:0] cur_div;
`ifdef DIVIDER_CTRL_PERIOD_CNT_EN
  logic        period_clr = 1'b0;
  logic [15:0] period_cnt;
`endif

  always #25 clk = ~clk;

  divider_ctrl #(.CNT_W(8), .RST_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DIVIDER_CTRL_PERIOD_CNT_EN
    .period_clr(period_clr),
    .period_cnt(period_cnt),
`endif
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_en    (div_en),
    .div_clk   (div_clk),
    .busy      (busy),
    .cur_div   (cur_div)
  );

  typedef struct packed {
    logic        busy;
    logic        div_clk;
    logic        div_en;
    logic        cfg_ready;
    logic        cfg_err;
    logic [7:0]  cur_div;
    logic [15:0] pcnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: position within the current period plus run/stop intent.
  bit m_active;
  bit m_stopping;
  int m_phase;
  int m_ratio;
  int m_pend;
  bit m_have_pend;
  bit m_err;
  int m_pc;

  function automatic obs_t m_obs();
    obs_t o;
    o.busy      = m_active;
    o.div_clk   = m_active && (m_phase < m_ratio / 2);
    o.div_en    = m_active && (m_phase == m_ratio - 1);
    o.cfg_ready = !m_have_pend;
    o.cfg_err   = m_err;
    o.cur_div   = 8'(m_ratio);
    o.pcnt      = 16'(m_pc);
    return o;
  endfunction

  task automatic m_reset();
    m_active = 0; m_stopping = 0; m_phase = 0; m_ratio = 4;
    m_pend = 0; m_have_pend = 0; m_err = 0; m_pc = 0;
  endtask

  task automatic m_step();
    bit bnd;
    bit go;
    bit fire;
    bit apply;
    bnd   = m_active && (m_phase == m_ratio - 1);
    go    = start && !stop;
    fire  = cfg_valid && !m_have_pend;
    apply = m_have_pend && (!m_active || bnd);
    if (!m_active) begin
      if (go) begin m_active = 1; m_stopping = 0; m_phase = 0; end
    end else begin
      m_phase = bnd ? 0 : m_phase + 1;
      if (!m_stopping) begin
        if (stop) begin
          if (bnd) m_active = 0;
          else     m_stopping = 1;
        end
      end else if (go) m_stopping = 0;
      else if (bnd)    m_active = 0;
      if (!m_active) begin m_phase = 0; m_stopping = 0; end
    end
`ifdef DIVIDER_CTRL_PERIOD_CNT_EN
    if (period_clr) m_pc = 0;
    else if (bnd)   m_pc = (m_pc + 1) % 65536;
`endif
    if (apply) begin m_ratio = m_pend; m_have_pend = 0; end
    m_err = fire && (int'(cfg_div) < 2);
    if (fire && int'(cfg_div) >= 2) begin m_pend = int'(cfg_div); m_have_pend = 1; end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  // Model: predicts the outputs that the next rising edge will produce.
  always @(negedge clk) begin
    if (rst) begin
      m_reset();
      exp_q.delete();
      exp_q.push_back(m_obs());
    end else begin
      m_step();
      exp_q.push_back(m_obs());
    end
  end

  // Monitor: compares the outputs currently presented against the oldest prediction.
  always @(negedge clk) begin
    obs_t e;
    if (!rst) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard_empty at %0t: got no prediction expected one", $time);
      end else begin
        e = exp_q.pop_front();
        chk("busy",      int'(busy),      int'(e.busy));
        chk("div_clk",   int'(div_clk),   int'(e.div_clk));
        chk("div_en",    int'(div_en),    int'(e.div_en));
        chk("cfg_ready", int'(cfg_ready), int'(e.cfg_ready));
        chk("cfg_err",   int'(cfg_err),   int'(e.cfg_err));
        chk("cur_div",   int'(cur_div),   int'(e.cur_div));
`ifdef DIVIDER_CTRL_PERIOD_CNT_EN
        chk("period_cnt", int'(period_cnt), int'(e.pcnt));
`endif
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until the model says the current cycle sits at the given phase.
  task automatic wait_phase(input int p);
    int k;
    k = 0;
    while (!(m_active && m_phase == p) && k < 300) begin
      cyc(1);
      k++;
    end
    if (k >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_phase timeout: got no phase %0d expected within 300 cycles", p);
    end
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // N=4 run
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(12);

    // ratio 5 offered mid-period
    wait_phase(1);
    cfg_valid = 1'b1; cfg_div = 8'd5; cyc(1); cfg_valid = 1'b0;
    cyc(16);

    // illegal ratios
    cfg_valid = 1'b1; cfg_div = 8'd1; cyc(1);
    cfg_div = 8'd0; cyc(1);
    cfg_valid = 1'b0; cyc(4);

    // N=6, stop at cnt=1
    cfg_valid = 1'b1; cfg_div = 8'd6; cyc(1); cfg_valid = 1'b0;
    cyc(14);
    wait_phase(1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(8);

    // start during DRAIN
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(3);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(1);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(10);

    // stop in boundary cycle
    wait_phase(5);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(4);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    cyc(3);

    // reset while running with a ratio pending
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(3);
    cfg_valid = 1'b1; cfg_div = 8'd9; cyc(1); cfg_valid = 1'b0;
    rst = 1'b1;
    #5;
    chk("rst_busy",      int'(busy),      0);
    chk("rst_div_clk",   int'(div_clk),   0);
    chk("rst_div_en",    int'(div_en),    0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_cfg_err",   int'(cfg_err),   0);
    chk("rst_cur_div",   int'(cur_div),   4);
    cyc(2);
    rst = 1'b0;
    cyc(5);

`ifdef DIVIDER_CTRL_PERIOD_CNT_EN
    // 10 periods at N=3, then clear on a boundary cycle
    period_clr = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd3; cyc(1);
    period_clr = 1'b0; cfg_valid = 1'b0; cyc(1);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(30);
    wait_phase(2);
    period_clr = 1'b1; cyc(1); period_clr = 1'b0;
    cyc(6);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(4);
`endif

    // randomized traffic
    repeat (3000) begin
      start     = ($urandom_range(0, 15) == 0);
      stop      = ($urandom_range(0, 23) == 0);
      cfg_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)       cfg_div = 8'($urandom_range(0, 1));
      else if ($urandom_range(0, 49) == 0) cfg_div = 8'($urandom_range(13, 255));
      else                                 cfg_div = 8'($urandom_range(2, 12));
`ifdef DIVIDER_CTRL_PERIOD_CNT_EN
      period_clr = ($urandom_range(0, 63) == 0);
`endif
      rst = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; rst = 1'b0;
`ifdef DIVIDER_CTRL_PERIOD_CNT_EN
    period_clr = 1'b0;
`endif
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
